alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one alu instance (aluop 000 AND, 001 OR, 010 ADD, 011 SUB, other -> 0; zero = in1==in2) between two requesters.
//  Requester 0 is the main execute datapath and requester 1 is the branch/address unit.
//  Arbitration is round-robin (or fixed), with valid/ready on each request port.
//  One registered result slot, with backpressure on the response side.
// PARAMETERS
//  FIXED_PRIO  0   1: requester 0 always wins; 0: round-robin.
//  CNT_W       16  Width of the grant counters (ARB_STATS_EN only).
// PORTS
//  clk          in   1   Clock; everything is on the rising edge.
//  reset        in   1   Synchronous, active-high reset.
//  req0_valid   in   1   Requester 0 has an operation.
//  req0_op      in   3   Requester 0 aluop.
//  req0_a       in   32  Requester 0 operand 1.
//  req0_b       in   32  Requester 0 operand 2.
//  req0_ready   out  1   Requester 0 operation accepted this cycle.
//  req1_valid   in   1   Requester 1 has an operation.
//  req1_op      in   3   Requester 1 aluop.
//  req1_a       in   32  Requester 1 operand 1.
//  req1_b       in   32  Requester 1 operand 2.
//  req1_ready   out  1   Requester 1 operation accepted this cycle.
//  rsp_valid    out  1   Result slot holds a result.
//  rsp_id       out  1   Requester that owns the result.
//  rsp_out      out  32  Registered alu_out.
//  rsp_zero     out  1   Registered alu_zero.
//  rsp_ready    in   1   Consumer takes the result this cycle.
//  grant0_cnt   out  CNT_W  Grants to requester 0 (ARB_STATS_EN only).
//  grant1_cnt   out  CNT_W  Grants to requester 1 (ARB_STATS_EN only).
// BEHAVIOUR
//  - Reset values: rsp_valid=0, rsp_id=0, rsp_out=0, rsp_zero=0, prio pointer=0 (req0 preferred), state=EMPTY.
//  - Reset mid-operation drops any held result with no response.
//  - slot_free = (state==EMPTY) | rsp_ready.
//  - Grant logic is combinational from the valids, the pointer and slot_free.
//  - At most one reqN_ready is high per cycle, and only when slot_free and reqN_valid.
//  - reqN_ready never depends on reqN_ready of the other port.
//  - Round-robin: if both valid, the requester equal to the pointer wins.
//  - After any grant the pointer = ~granted_id; it is unchanged with no grant. A lone valid always wins.
//  - FIXED_PRIO=1: requester 0 always wins and the pointer is ignored.
//  - Latency: grant in cycle N -> rsp_valid=1 with the result in cycle N+1.
//  - Operands are muxed combinationally into the alu; alu outputs are captured at the grant edge.
//  - FSM EMPTY: grant -> FULL (load slot); no grant -> stay.
//  - FSM FULL: rsp_ready & grant -> FULL (slot reloaded back-to-back, one result per cycle).
//  - FSM FULL: rsp_ready & no grant -> EMPTY.
//  - FSM FULL: ~rsp_ready -> stay; both readies stay 0; rsp_* are stable.
//  - The requester must hold op/a/b stable while reqN_valid & ~reqN_ready.
//  - Arithmetic is 32-bit wraparound with no overflow flag. Undefined op (1xx) returns rsp_out=0, and rsp_zero is still a==b.
// CONFIGURATION
//  - ARB_STATS_EN defined: grant0_cnt/grant1_cnt are present.
//  - Each counter increments on its grant and saturates at all-ones.
//  - Both counters reset to 0.
//  - ARB_STATS_EN undefined: the counter ports and logic are absent; all other behaviour is identical.
// TESTING
//  - Basic ADD: req0 ADD a=5 b=7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_out=12, rsp_zero=0.
//  - Round-robin: both valid every cycle (req0 SUB 9-9, req1 OR F0|0F), rsp_ready=1 -> grants alternate 0,1,0,1.
//  - Round-robin results: ids 0,1,0,1; results 0 (zero=1) and 0xFF (zero=0).
//  - Backpressure: rsp_ready=0 for 3 cycles with result held -> both readies 0 and rsp_* stable.
//  - Release: rsp_ready=1 -> a pending req1 is granted the same cycle and its result appears the next cycle.
//  - Wrap and undefined op: req1 SUB 0-1 -> 0xFFFFFFFF. req0 op=111, a=b=3 -> rsp_out=0, rsp_zero=1.
//  - Reset while FULL -> next cycle rsp_valid=0, pointer=0; with both valid, req0 is granted first.
//  - ARB_STATS_EN with CNT_W=2: 5 grants to req0 -> grant0_cnt reads 1,2,3,3,3 and grant1_cnt stays 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one 32-bit ALU between two valid/ready requesters
//            (req0 = execute datapath, req1 = branch/address unit), with
//            round-robin or fixed-priority arbitration and a single
//            registered result slot that honours response backpressure.
// Options  : ARB_STATS_EN - adds saturating grant counters grant0_cnt and
//            grant1_cnt (width CNT_W).
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_out,
    output logic        rsp_zero,
    input  logic        rsp_ready
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
`endif
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q;
    logic        ptr_q;        // requester preferred when both are valid
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [31:0] rsp_out_q;
    logic        rsp_zero_q;

    logic        slot_free;
    logic        gnt0;
    logic        gnt1;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_zero;

    // The slot can accept a new result if empty or being drained this cycle.
    assign slot_free = (state_q == EMPTY) || rsp_ready;

    // Grant selection: each ready depends only on valids, pointer and slot state.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (FIXED_PRIO) begin
            gnt0 = slot_free & req0_valid;
            gnt1 = slot_free & req1_valid & ~req0_valid;
        end else begin
            gnt0 = slot_free & req0_valid & (~req1_valid | ~ptr_q);
            gnt1 = slot_free & req1_valid & (~req0_valid |  ptr_q);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Operand mux in front of the shared ALU, then the ALU itself.
    always_comb begin
        alu_op   = gnt1 ? req1_op : req0_op;
        alu_a    = gnt1 ? req1_a  : req0_a;
        alu_b    = gnt1 ? req1_b  : req0_b;
        alu_zero = (alu_a == alu_b);
        case (alu_op)
            3'b000:  alu_out = alu_a & alu_b;
            3'b001:  alu_out = alu_a | alu_b;
            3'b010:  alu_out = alu_a + alu_b;
            3'b011:  alu_out = alu_a - alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    // Result-slot FSM; the pointer flips away from whoever was just granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            ptr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= 32'd0;
            rsp_zero_q  <= 1'b0;
        end else begin
            if (gnt0 || gnt1) begin
                ptr_q       <= gnt0;
                state_q     <= FULL;
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= gnt1;
                rsp_out_q   <= alu_out;
                rsp_zero_q  <= alu_zero;
            end else begin
                case (state_q)
                    EMPTY: begin
                        state_q <= EMPTY;
                    end
                    FULL: begin
                        if (rsp_ready) begin
                            state_q     <= EMPTY;
                            rsp_valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q     <= EMPTY;
                        rsp_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_zero  = rsp_zero_q;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] grant0_cnt_q;
    logic [CNT_W-1:0] grant1_cnt_q;

    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant0_cnt_q <= '0;
            grant1_cnt_q <= '0;
        end else begin
            if (gnt0 && (grant0_cnt_q != '1)) begin
                grant0_cnt_q <= grant0_cnt_q + CNT_W'(1);
            end
            if (gnt1 && (grant1_cnt_q != '1)) begin
                grant1_cnt_q <= grant1_cnt_q + CNT_W'(1);
            end
        end
    end

    assign grant0_cnt = grant0_cnt_q;
    assign grant1_cnt = grant1_cnt_q;
`endif

endmodule
`default_nettype wire
